// File: rtl/traffic_intersection_ctrl.sv
// Timed two-road intersection controller with all-red clearance, a latched
// pedestrian walk phase and a flashing-yellow maintenance mode.
module traffic_intersection_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GREEN_CYC  = 20,
    parameter int unsigned YELLOW_CYC = 4,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned PED_CYC    = 10,
    parameter int unsigned FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       flash_mode,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    // Timer reload values: each timed state runs for exactly its duration.
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           next_timed;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink;
    logic             timer_done;
    logic             enter_ped;

    // Duration reload for the state being entered.
    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        logic [CNT_W-1:0] ld;
        ld = ALLRED_LD;
        case (s)
            NS_GREEN:  ld = GREEN_LD;
            NS_YELLOW: ld = YELLOW_LD;
            ALLRED_A:  ld = ALLRED_LD;
            EW_GREEN:  ld = GREEN_LD;
            EW_YELLOW: ld = YELLOW_LD;
            ALLRED_B:  ld = ALLRED_LD;
            PED_WALK:  ld = PED_LD;
            FLASH:     ld = ALLRED_LD;
            default:   ld = ALLRED_LD;
        endcase
        return ld;
    endfunction

    // Successor of each timed state on timer expiry.
    always_comb begin
        next_timed = ALLRED_B;
        case (state)
            NS_GREEN:  next_timed = NS_YELLOW;
            NS_YELLOW: next_timed = ALLRED_A;
            ALLRED_A:  next_timed = EW_GREEN;
            EW_GREEN:  next_timed = EW_YELLOW;
            EW_YELLOW: next_timed = ALLRED_B;
            ALLRED_B:  next_timed = ped_pending ? PED_WALK : NS_GREEN;
            PED_WALK:  next_timed = NS_GREEN;
            FLASH:     next_timed = ALLRED_B;
            default:   next_timed = ALLRED_B;
        endcase
    end

    assign timer_done = (timer == '0);

    // Walk is entered only from a natural ALLRED_B expiry; flash takes priority.
    assign enter_ped = enable && !flash_mode && (state == ALLRED_B) &&
                       timer_done && ped_pending;

    // Phase sequencer, phase timer, blink generator and pedestrian latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ALLRED_B;
            timer       <= ALLRED_LD;
            blink_cnt   <= '0;
            blink       <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            // The latch runs on every clock; requests during walk are dropped.
            if (enter_ped) begin
                ped_pending <= 1'b0;
            end else if (ped_req && (state != PED_WALK)) begin
                ped_pending <= 1'b1;
            end

            if (enable) begin
                if (state == FLASH) begin
                    if (!flash_mode) begin
                        state <= ALLRED_B;
                        timer <= ALLRED_LD;
                        blink <= 1'b0;
                    end else if (blink_cnt == '0) begin
                        blink     <= ~blink;
                        blink_cnt <= FLASH_LD;
                    end else begin
                        blink_cnt <= blink_cnt - CNT_ONE;
                    end
                end else if (flash_mode) begin
                    state     <= FLASH;
                    blink     <= 1'b1;
                    blink_cnt <= FLASH_LD;
                end else if (timer_done) begin
                    state <= next_timed;
                    timer <= load_for(next_timed);
                end else begin
                    timer <= timer - CNT_ONE;
                end
            end
        end
    end

    // Signal head decode from the registered state; no added latency.
    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        ped_walk  = 1'b0;
        case (state)
            NS_GREEN: begin
                ns_green = 1'b1;
                ew_red   = 1'b1;
            end
            NS_YELLOW: begin
                ns_yellow = 1'b1;
                ew_red    = 1'b1;
            end
            EW_GREEN: begin
                ew_green = 1'b1;
                ns_red   = 1'b1;
            end
            EW_YELLOW: begin
                ew_yellow = 1'b1;
                ns_red    = 1'b1;
            end
            ALLRED_A, ALLRED_B: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
            end
            PED_WALK: begin
                ns_red   = 1'b1;
                ew_red   = 1'b1;
                ped_walk = 1'b1;
            end
            FLASH: begin
                ns_yellow = blink;
                ew_yellow = blink;
            end
            default: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
            end
        endcase
    end

    assign phase = 3'(state);

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl: expected phase, lights and
// pedestrian latch per cycle are queued as stimulus is applied and checked
// mid-cycle against the DUT.
module tb_traffic_intersection_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       flash_mode;
    logic       ped_req;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       ped_walk;
    logic       ped_pending;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0] phase;
        logic [6:0] lights;
        logic       pend;
    } exp_t;

    exp_t sb_q[$];

    logic [6:0] obs_lights;
    assign obs_lights = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};

    traffic_intersection_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .flash_mode  (flash_mode),
        .ped_req     (ped_req),
        .ns_red      (ns_red),
        .ns_yellow   (ns_yellow),
        .ns_green    (ns_green),
        .ew_red      (ew_red),
        .ew_yellow   (ew_yellow),
        .ew_green    (ew_green),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    // Lights {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} required for each phase.
    function automatic logic [6:0] lights_for(input logic [2:0] ph, input logic blk);
        logic [6:0] l;
        case (ph)
            3'd0:    l = 7'b0011000;
            3'd1:    l = 7'b0101000;
            3'd2:    l = 7'b1001000;
            3'd3:    l = 7'b1000010;
            3'd4:    l = 7'b1000100;
            3'd5:    l = 7'b1001000;
            3'd6:    l = 7'b1001001;
            default: l = {1'b0, blk, 1'b0, 1'b0, blk, 1'b0, 1'b0};
        endcase
        return l;
    endfunction

    // Phase after e enabled cycles from reset, with walks starting at
    // first, first+62, ... (a 52-cycle road cycle plus a 10-cycle walk).
    function automatic logic [2:0] exp_phase(input int e, input int first, input int walks);
        int off;
        int s;
        int n;
        int m;
        off = 0;
        for (int k = 0; k < walks; k++) begin
            s = first + 62 * k;
            if (e >= s && e < s + 10) return 3'd6;
            if (e >= s + 10) off += 10;
        end
        n = e - off;
        if (n < 2) return 3'd5;
        m = (n - 2) % 52;
        if (m < 20) return 3'd0;
        if (m < 24) return 3'd1;
        if (m < 26) return 3'd2;
        if (m < 46) return 3'd3;
        if (m < 50) return 3'd4;
        return 3'd5;
    endfunction

    task automatic compare_front(input string tag);
        exp_t y;
        y = sb_q.pop_front();
        n_checks++;
        assert (phase === y.phase) else begin
            n_fail++;
            $error("FAIL %s phase observed=%0d expected=%0d", tag, phase, y.phase);
        end
        n_checks++;
        assert (obs_lights === y.lights) else begin
            n_fail++;
            $error("FAIL %s lights observed=%b expected=%b", tag, obs_lights, y.lights);
        end
        n_checks++;
        assert (ped_pending === y.pend) else begin
            n_fail++;
            $error("FAIL %s ped_pending observed=%b expected=%b", tag, ped_pending, y.pend);
        end
    endtask

    // Called #1 after a rising edge with inputs already driven for this cycle.
    task automatic check_cycle(input logic [2:0] ph, input logic pend, input logic blk,
                               input string name, input int c);
        exp_t x;
        x.phase  = ph;
        x.lights = lights_for(ph, blk);
        x.pend   = pend;
        sb_q.push_back(x);
        @(negedge clk);
        compare_front($sformatf("%s c=%0d", name, c));
        @(posedge clk);
        #1;
    endtask

    // Assert reset for one cycle, check reset values, release into cycle 0.
    task automatic do_reset(input string name);
        exp_t x;
        reset_n  = 1'b0;
        x.phase  = 3'd5;
        x.lights = lights_for(3'd5, 1'b0);
        x.pend   = 1'b0;
        sb_q.push_back(x);
        @(negedge clk);
        compare_front(name);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        flash_mode = 1'b0;
        ped_req    = 1'b0;
        @(posedge clk);
        #1;

        // Free-running sequence, enable constant.
        enable = 1'b1;
        do_reset("reset1");
        for (int c = 0; c < 60; c++)
            check_cycle(exp_phase(c, 54, 0), 1'b0, 1'b0, "normal", c);

        // Pedestrian pulse during EW_GREEN served after ALLRED_B.
        do_reset("reset2");
        for (int c = 0; c < 70; c++) begin
            ped_req = (c == 30);
            check_cycle(exp_phase(c, 54, 1), (c >= 31 && c < 54), 1'b0, "ped_pulse", c);
        end
        ped_req = 1'b0;

        // Enable on alternate cycles; request latched on a disabled cycle.
        do_reset("reset3");
        for (int c = 0; c < 140; c++) begin
            enable  = (c % 2 == 0);
            ped_req = (c == 61);
            check_cycle(exp_phase((c + 1) / 2, 54, 1), (c >= 62 && c < 107), 1'b0,
                        "enable_toggle", c);
        end
        enable  = 1'b1;
        ped_req = 1'b0;

        // Flash mode from cycle 10 to 39, request held through FLASH.
        do_reset("reset4");
        for (int c = 0; c < 57; c++) begin
            logic [2:0] ph;
            logic       blk;
            flash_mode = (c >= 10 && c < 40);
            ped_req    = (c == 20);
            if (c < 11)      ph = exp_phase(c, 54, 0);
            else if (c <= 40) ph = 3'd7;
            else if (c < 43) ph = 3'd5;
            else if (c < 53) ph = 3'd6;
            else             ph = 3'd0;
            blk = (c >= 11 && c <= 40) ? (((c - 11) / 8) % 2 == 0) : 1'b0;
            check_cycle(ph, (c >= 21 && c < 43), blk, "flash", c);
        end
        flash_mode = 1'b0;
        ped_req    = 1'b0;

        // Request held across the whole walk: discarded, then relatched.
        do_reset("reset5");
        for (int c = 0; c < 128; c++) begin
            ped_req = (c >= 30 && c <= 64);
            check_cycle(exp_phase(c, 54, 2), ((c >= 31 && c < 54) || (c >= 65 && c < 116)),
                        1'b0, "ped_held", c);
        end
        ped_req = 1'b0;

        // Reset mid-EW_GREEN with a request pending, then restart.
        do_reset("reset6");
        for (int c = 0; c < 35; c++) begin
            ped_req = (c == 30);
            check_cycle(exp_phase(c, 54, 1), (c >= 31), 1'b0, "pre_reset", c);
        end
        ped_req = 1'b0;
        do_reset("mid_reset");
        for (int c = 0; c < 30; c++)
            check_cycle(exp_phase(c, 54, 0), 1'b0, 1'b0, "post_reset", c);

        // Request coincident with ALLRED_B expiry waits a full road cycle.
        do_reset("reset7");
        for (int c = 0; c < 120; c++) begin
            ped_req = (c == 53);
            check_cycle(exp_phase(c, 106, 1), (c >= 54 && c < 106), 1'b0, "ped_at_expiry", c);
        end
        ped_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
